// File: rtl/calc_bcd_display.sv
// calc_bcd_display
// Display stage for the calculator breadboard.
// Converts an unsigned W-bit result into D packed BCD digits using
// shift-add-3 (double-dabble), one bit per clock. It also produces a
// leading-zero blanking mask and latches the error vector that came with
// the value.
//
// Ports:
//   CLK    in   rising-edge clock
//   RST_N  in   synchronous active-low reset
//   START  in   conversion request; ignored while BUSY=1
//   VAL    in   W-bit unsigned value to convert
//   ERR    in   error vector (bit0 overflow, bit1 divide/mod by zero)
//   BUSY   out  conversion in progress
//   DONE   out  one-cycle pulse when BCD/BLANK/ERRL are updated
//   BCD    out  4*D-bit packed digits; [3:0] is the ones digit
//   BLANK  out  D-bit mask; 1 = leading-zero digit to blank; bit0 is always 0
//   ERRL   out  ERR as captured together with the converted value
module calc_bcd_display #(
    parameter int W = 32,
    parameter int D = 10
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [W-1:0]     VAL,
    input  logic [1:0]       ERR,
    output logic             BUSY,
    output logic             DONE,
    output logic [4*D-1:0]   BCD,
    output logic [D-1:0]     BLANK,
    output logic [1:0]       ERRL
);

    localparam int CW = $clog2(W + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    // Reset value of the blanking mask: every digit blanked except the ones digit.
    localparam logic [D-1:0] BLANK_RST = {{(D-1){1'b1}}, 1'b0};

    logic [1:0]     state_q, state_d;
    logic [W-1:0]   bin_q,   bin_d;
    logic [4*D-1:0] dig_q,   dig_d;
    logic [CW-1:0]  cnt_q,   cnt_d;
    logic [1:0]     err_q,   err_d;
    logic           busy_q,  busy_d;
    logic           done_q,  done_d;
    logic [4*D-1:0] bcd_q,   bcd_d;
    logic [D-1:0]   blank_q, blank_d;
    logic [1:0]     errl_q,  errl_d;

    logic [4*D-1:0] adj_s;
    logic [D-1:0]   blank_s;
    logic           zero_above_s;

    // Add-3 correction on each digit that is >= 5, applied before the shift.
    // A digit never exceeds 9 before correction, so the sum fits in 4 bits.
    always_comb begin
        adj_s = '0;
        for (int k = 0; k < D; k++) begin
            if (dig_q[4*k +: 4] >= 4'd5) begin
                adj_s[4*k +: 4] = dig_q[4*k +: 4] + 4'd3;
            end else begin
                adj_s[4*k +: 4] = dig_q[4*k +: 4];
            end
        end
    end

    // Leading-zero mask: digit k is blanked when it and every digit above it are zero.
    always_comb begin
        blank_s      = '0;
        zero_above_s = 1'b1;
        for (int k = D - 1; k >= 1; k--) begin
            zero_above_s = zero_above_s & (dig_q[4*k +: 4] == 4'd0);
            blank_s[k]   = zero_above_s;
        end
        blank_s[0] = 1'b0;
    end

    // Next-state logic: capture, serial conversion, result publish.
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        dig_d   = dig_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        bcd_d   = bcd_q;
        blank_d = blank_q;
        errl_d  = errl_q;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    bin_d  = VAL;
                    err_d  = ERR;
                    dig_d  = '0;
                    cnt_d  = '0;
                    busy_d = 1'b1;
                    // Divide-by-zero has no meaningful value, so skip the conversion.
                    if (ERR[1]) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // Shift {digits, binary} left by one, using the corrected digits.
                dig_d = {adj_s[4*D-2:0], bin_q[W-1]};
                bin_d = {bin_q[W-2:0], 1'b0};
                cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                if (cnt_q == CW'(W - 1)) begin
                    state_d = ST_FINISH;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_FINISH: begin
                if (err_q[1]) begin
                    bcd_d   = {D{4'hE}};
                    blank_d = '0;
                end else begin
                    bcd_d   = dig_q;
                    blank_d = blank_s;
                end
                errl_d  = err_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            bin_q   <= '0;
            dig_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bcd_q   <= '0;
            blank_q <= BLANK_RST;
            errl_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            dig_q   <= dig_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bcd_q   <= bcd_d;
            blank_q <= blank_d;
            errl_q  <= errl_d;
        end
    end

    assign BUSY  = busy_q;
    assign DONE  = done_q;
    assign BCD   = bcd_q;
    assign BLANK = blank_q;
    assign ERRL  = errl_q;

endmodule

// File: tb/tb_calc_bcd_display.sv
// tb_calc_bcd_display
// Directed table-driven bench for calc_bcd_display (W=32, D=10), plus
// hand-written sequences for ignored START, START in the DONE cycle and
// reset during a conversion.
module tb_calc_bcd_display;

    logic        CLK;
    logic        RST_N;
    logic        START;
    logic [31:0] VAL;
    logic [1:0]  ERR;
    logic        BUSY;
    logic        DONE;
    logic [39:0] BCD;
    logic [9:0]  BLANK;
    logic [1:0]  ERRL;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] val;
        logic [1:0]  err;
        logic [39:0] bcd;
        logic [9:0]  blank;
        int          lat;
    } vec_t;

    vec_t vecs [10];

    calc_bcd_display #(.W(32), .D(10)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .START (START),
        .VAL   (VAL),
        .ERR   (ERR),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .BCD   (BCD),
        .BLANK (BLANK),
        .ERRL  (ERRL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called at the negedge right after the capture edge N. Returns the number
    // of edges after N at which DONE was first seen, and the BUSY-high cycle count.
    task automatic wait_done(output int k, output int bc);
        k  = 0;
        bc = 0;
        while (DONE !== 1'b1 && k < 100) begin
            if (BUSY === 1'b1) bc++;
            @(negedge CLK);
            k++;
        end
        if (k >= 100) begin
            n_vec++;
            n_bad++;
            $display("FAIL done_timeout: no DONE within %0d cycles", k);
        end
    endtask

    initial begin
        int k;
        int bc;
        vecs[0] = '{32'd0,          2'b00, 40'h0000000000, 10'b1111111110, 33};
        vecs[1] = '{32'd150,        2'b00, 40'h0000000150, 10'b1111111000, 33};
        vecs[2] = '{32'hFFFFFFFF,   2'b01, 40'h4294967295, 10'b0000000000, 33};
        vecs[3] = '{32'd7,          2'b10, 40'hEEEEEEEEEE, 10'b0000000000, 1};
        vecs[4] = '{32'd1000000000, 2'b00, 40'h1000000000, 10'b0000000000, 33};
        vecs[5] = '{32'd9,          2'b00, 40'h0000000009, 10'b1111111110, 33};
        vecs[6] = '{32'd10,         2'b00, 40'h0000000010, 10'b1111111100, 33};
        vecs[7] = '{32'd12345678,   2'b00, 40'h0012345678, 10'b1100000000, 33};
        vecs[8] = '{32'd5,          2'b11, 40'hEEEEEEEEEE, 10'b0000000000, 1};
        vecs[9] = '{32'd42,         2'b01, 40'h0000000042, 10'b1111111100, 33};

        RST_N = 1'b0;
        START = 1'b0;
        VAL   = 32'd0;
        ERR   = 2'b00;
        repeat (3) @(negedge CLK);
        chk("rst_busy",  64'(BUSY),  64'(1'b0));
        chk("rst_done",  64'(DONE),  64'(1'b0));
        chk("rst_bcd",   64'(BCD),   64'(40'h0));
        chk("rst_blank", 64'(BLANK), 64'(10'b1111111110));
        chk("rst_errl",  64'(ERRL),  64'(2'b00));
        RST_N = 1'b1;
        @(negedge CLK);

        // Table: apply each vector, then scramble VAL/ERR after capture.
        for (int i = 0; i < 10; i++) begin
            VAL   = vecs[i].val;
            ERR   = vecs[i].err;
            START = 1'b1;
            @(negedge CLK);
            START = 1'b0;
            VAL   = 32'hDEADBEEF;
            ERR   = 2'b10;
            wait_done(k, bc);
            chk($sformatf("v%0d_lat", i),   64'(k),        64'(vecs[i].lat));
            chk($sformatf("v%0d_busy", i),  64'(bc),       64'(vecs[i].lat));
            chk($sformatf("v%0d_bcd", i),   64'(BCD),      64'(vecs[i].bcd));
            chk($sformatf("v%0d_blank", i), 64'(BLANK),    64'(vecs[i].blank));
            chk($sformatf("v%0d_errl", i),  64'(ERRL),     64'(vecs[i].err));
            @(negedge CLK);
            chk($sformatf("v%0d_pulse", i), 64'(DONE),     64'(1'b0));
            chk($sformatf("v%0d_hold", i),  64'(BCD),      64'(vecs[i].bcd));
            ERR = 2'b00;
        end

        // START while busy is ignored; START in the DONE cycle is accepted.
        VAL   = 32'd1234;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (9) @(negedge CLK);
        VAL   = 32'd99;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        chk("seq1_hold_mid", 64'(BCD), 64'(40'h0000000042));
        wait_done(k, bc);
        chk("seq1_lat", 64'(k),   64'(33 - 10));
        chk("seq1_bcd", 64'(BCD), 64'(40'h0000001234));
        VAL   = 32'd99;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        wait_done(k, bc);
        chk("seq2_lat",   64'(k),     64'(33));
        chk("seq2_bcd",   64'(BCD),   64'(40'h0000000099));
        chk("seq2_blank", 64'(BLANK), 64'(10'b1111111100));

        // Reset mid-conversion aborts without a DONE pulse.
        VAL   = 32'd1234;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (14) @(negedge CLK);
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        chk("mrst_busy",  64'(BUSY),  64'(1'b0));
        chk("mrst_done",  64'(DONE),  64'(1'b0));
        chk("mrst_bcd",   64'(BCD),   64'(40'h0));
        chk("mrst_blank", 64'(BLANK), 64'(10'b1111111110));
        k = 0;
        for (int c = 0; c < 40; c++) begin
            if (DONE === 1'b1) k++;
            @(negedge CLK);
        end
        chk("mrst_no_done", 64'(k), 64'(0));
        VAL   = 32'd1234;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        wait_done(k, bc);
        chk("mrst_next_lat", 64'(k),    64'(33));
        chk("mrst_next_bcd", 64'(BCD),  64'(40'h0000001234));
        chk("mrst_next_errl", 64'(ERRL), 64'(2'b00));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
